// File: rtl/glitch_monitor_if.sv
// Bus bundle between a glitch_monitor and the block that arms it and feeds
// it delay-line ones-count samples.
interface glitch_monitor_if #(
   parameter int Q_WIDTH  = 7,
   parameter int TS_WIDTH = 16
);
   logic                arm;
   logic                stop;
   logic                q_valid;
   logic [Q_WIDTH-1:0]  q_in;
   logic                busy;
   logic                done;
   logic                glitch;
   logic [Q_WIDTH-1:0]  q_min;
   logic [Q_WIDTH-1:0]  q_max;
   logic [TS_WIDTH-1:0] below_cnt;
   logic [TS_WIDTH-1:0] first_ts;
   logic [TS_WIDTH-1:0] n_samples;

   modport master (
      output arm, stop, q_valid, q_in,
      input  busy, done, glitch, q_min, q_max, below_cnt, first_ts, n_samples
   );

   modport slave (
      input  arm, stop, q_valid, q_in,
      output busy, done, glitch, q_min, q_max, below_cnt, first_ts, n_samples
   );
endinterface

// File: rtl/glitch_monitor.sv
// Windowed supply-glitch monitor: while armed, tracks min/max of the
// delay-line ones-count, counts samples at or below THRESH and records the
// window timestamp of the first such sample. Results stay put until re-armed.
module glitch_monitor #(
   parameter int Q_WIDTH  = 7,
   parameter int THRESH   = 15,
   parameter int TS_WIDTH = 16,
   parameter int WINDOW   = 65535
) (
   input  logic            clk,
   input  logic            reset,
   glitch_monitor_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

   localparam logic [TS_WIDTH-1:0] TS_ONES  = '1;
   localparam logic [TS_WIDTH-1:0] TS_LAST  = TS_WIDTH'(WINDOW - 1);
   localparam logic [31:0]         THRESH_U = 32'(THRESH);

   state_t              r_state;
   logic [TS_WIDTH-1:0] r_ts;
   logic                r_busy;
   logic                r_done;
   logic                r_glitch;
   logic [Q_WIDTH-1:0]  r_q_min;
   logic [Q_WIDTH-1:0]  r_q_max;
   logic [TS_WIDTH-1:0] r_below_cnt;
   logic [TS_WIDTH-1:0] r_first_ts;
   logic [TS_WIDTH-1:0] r_n_samples;

   logic                w_low;
   logic                w_close;

   // Sample-below-threshold and window-close conditions for the current cycle
   always_comb begin
      w_low   = bus.q_valid && ({{(32-Q_WIDTH){1'b0}}, bus.q_in} <= THRESH_U);
      w_close = bus.stop || (r_ts == TS_LAST);
   end

   // Window FSM plus accumulators; first_ts all-ones means "no glitch yet"
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_ts        <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_glitch    <= 1'b0;
         r_q_min     <= '1;
         r_q_max     <= '0;
         r_below_cnt <= '0;
         r_first_ts  <= '1;
         r_n_samples <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (bus.arm) begin
                  r_state     <= ARMED;
                  r_busy      <= 1'b1;
                  r_ts        <= '0;
                  r_glitch    <= 1'b0;
                  r_q_min     <= '1;
                  r_q_max     <= '0;
                  r_below_cnt <= '0;
                  r_first_ts  <= '1;
                  r_n_samples <= '0;
               end
            end
            ARMED: begin
               r_ts <= r_ts + 1'b1;
               if (bus.q_valid) begin
                  if (r_n_samples != TS_ONES) r_n_samples <= r_n_samples + 1'b1;
                  if (bus.q_in < r_q_min) r_q_min <= bus.q_in;
                  if (bus.q_in > r_q_max) r_q_max <= bus.q_in;
               end
               if (w_low) begin
                  r_glitch <= 1'b1;
                  if (r_below_cnt != TS_ONES) r_below_cnt <= r_below_cnt + 1'b1;
                  if (r_first_ts == TS_ONES) r_first_ts <= r_ts;
               end
               if (w_close) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.glitch    = r_glitch;
   assign bus.q_min     = r_q_min;
   assign bus.q_max     = r_q_max;
   assign bus.below_cnt = r_below_cnt;
   assign bus.first_ts  = r_first_ts;
   assign bus.n_samples = r_n_samples;

endmodule

// File: doc/glitch_monitor.md
GLITCH_MONITOR -- requirements
Module: glitch_monitor

Interface
REQ-001 The block SHALL expose these parameters, one per line (name, default, meaning):
- Q_WIDTH, 7, width of the ones-count sample.
- THRESH, 15, glitch threshold; a sample at or below it is a glitch.
- TS_WIDTH, 16, width of the window timestamp and below-threshold counter.
- WINDOW, 65535, maximum ARMED cycles before forced close; 1 <= WINDOW <= 2^TS_WIDTH-1.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, synchronous active-high reset.
- arm, in, 1, single-cycle pulse that opens a measurement window.
- stop, in, 1, single-cycle pulse that closes the window.
- q_valid, in, 1, q_in is valid this cycle.
- q_in, in, Q_WIDTH, registered ones-count from the delay-line sensor.
- busy, out, 1, high while in ARMED.
- done, out, 1, one-cycle pulse when results are final.
- glitch, out, 1, at least one sample <= THRESH was seen in the window.
- q_min, out, Q_WIDTH, minimum valid sample in the window.
- q_max, out, Q_WIDTH, maximum valid sample in the window.
- below_cnt, out, TS_WIDTH, number of valid samples <= THRESH, saturating.
- first_ts, out, TS_WIDTH, window timestamp of the first glitch sample.
- n_samples, out, TS_WIDTH, number of valid samples in the window, saturating.

Function
REQ-004 The FSM SHALL have three states: IDLE, ARMED and DONE.
REQ-005 IDLE SHALL go to ARMED on the cycle after arm=1; stop SHALL be ignored in IDLE.
REQ-006 On the arm cycle the block SHALL clear the accumulators:
- glitch=0, q_min=all-ones, q_max=0, below_cnt=0, n_samples=0.
- first_ts=all-ones, used as the "none" sentinel.
- ts=0.
REQ-007 In ARMED, ts SHALL increment by 1 every clock; the first ARMED cycle has ts=0.
REQ-008 In each ARMED cycle with q_valid=1, the block SHALL update these outputs, visible the next cycle:
- n_samples += 1.
- q_min = min(q_min, q_in).
- q_max = max(q_max, q_in).
REQ-009 A valid ARMED sample with q_in <= THRESH (unsigned compare) SHALL additionally:
- set glitch=1;
- increment below_cnt;
- load first_ts with the current ts if first_ts still holds the sentinel.
REQ-010 below_cnt and n_samples SHALL saturate at 2^TS_WIDTH-1 and never wrap.
REQ-011 ARMED SHALL go to DONE after the first cycle in which either condition holds:
- stop=1;
- ts == WINDOW-1.
The sample present in that closing cycle SHALL still be accumulated.
REQ-012 stop and timeout in the same cycle SHALL produce a single transition and a single done pulse.
REQ-013 arm asserted while in ARMED or DONE SHALL be ignored; it does not restart the window.
REQ-014 DONE SHALL last exactly one cycle:
- done=1 in that cycle;
- return to IDLE on the next cycle.
REQ-015 busy SHALL equal 1 exactly while the state is ARMED.
REQ-016 Outside ARMED, all result outputs SHALL hold their last values until the next arm.
REQ-017 q_valid=0 cycles SHALL advance ts and change no accumulator.
REQ-018 A window with zero valid samples SHALL report:
- glitch=0, below_cnt=0, n_samples=0;
- q_min=all-ones, q_max=0, first_ts=sentinel.
REQ-019 All outputs SHALL be registered; there is no combinational path from input to output.

Reset
REQ-020 Reset SHALL force these values on the next clock edge, regardless of state:
- state=IDLE, busy=0, done=0, glitch=0;
- q_min=all-ones, q_max=0;
- below_cnt=0, n_samples=0, first_ts=all-ones, ts=0.
REQ-021 Reset during ARMED SHALL abort the window with no done pulse.
REQ-022 Reset SHALL take priority over arm, stop and q_valid in the same cycle.

Verification
REQ-023 Basic glitch window: arm; q_valid=1 with q_in = 40,40,12,40,9,40; stop with the last sample. Required response:
- one done pulse;
- glitch=1, q_min=9, q_max=40;
- below_cnt=2, first_ts=2, n_samples=6.
REQ-024 Threshold boundary: samples 16,16,15. Required response: below_cnt=1 (15 counts, 16 does not), glitch=1, first_ts=2.
REQ-025 Timeout with WINDOW=8 and no stop: required response is
- busy high exactly 8 cycles;
- done on the following cycle;
- n_samples=8 with q_valid held high.
REQ-026 Simultaneous events:
- stop coincident with the timeout cycle gives exactly one done.
- arm during ARMED is ignored and the accumulators are not cleared.
- arm and stop together in IDLE: the window opens.
REQ-027 Reset mid-window: arm; 3 glitch samples; reset. Required response:
- no done pulse;
- outputs at reset values next cycle (glitch=0, first_ts=16'hFFFF).
A following normal window reports fresh values.
REQ-028 Empty window and saturation:
- arm then stop with q_valid=0 gives the REQ-018 values.
- With TS_WIDTH=4 and WINDOW=15, 15 valid glitch samples give below_cnt=15 and no wrap.
